impl_window_checker: RTL and testbench
======================================

# impl_window_checker

Synthesizable hardware monitor for the implication property `ante |-> ##[MIN_DLY:MAX_DLY] cons`. Every antecedent starts one attempt. A consequent falling inside the window of the oldest attempt retires it as a pass. An attempt whose window closes without a consequent retires as a fail. The block sits beside a request/response interface as the runtime counterpart of the `|->`/`|=>` assertions: it sees the responder's outputs the same way a simulator checker would, and reports results in silicon and in emulation.

## Interface
- `MIN_DLY`, 1 — earliest consequent cycle relative to the antecedent cycle; 0 gives overlapped (`|->`) semantics, 1 gives `|=>`.
- `MAX_DLY`, 4 — latest consequent cycle; must satisfy MIN_DLY ≤ MAX_DLY < 2^CNT_W−1.
- `DEPTH`, 4 — maximum outstanding attempts; a power of two ≥ 2.
- `CNT_W`, 8 — width of the free-running timestamp counter.
- `clk` in 1 — single clock; all logic is rising-edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `en_i` in 1 — checker enable; low flushes all attempts.
- `ante_i` in 1 — antecedent, sampled every cycle.
- `cons_i` in 1 — consequent, sampled every cycle.
- `pass_o` out 1 — one-cycle pulse: an attempt passed.
- `fail_o` out 1 — one-cycle pulse: an attempt's window expired.
- `overflow_o` out 1 — one-cycle pulse: an antecedent was dropped because the tracker was full.
- `pending_o` out $clog2(DEPTH+1) — number of outstanding attempts.
- `fail_cnt_o` out 16 — saturating fail count.
- `err_sticky_o` out 1 — sticky error flag (see Configuration).
- `first_fail_ts_o` out CNT_W — timestamp of the first fail (see Configuration).

## Operation
- `now` is a CNT_W free-running counter that wraps modulo 2^CNT_W.
- Pending attempts are held in a DEPTH-entry FIFO of start stamps. The head is always the oldest attempt.
- Head age is computed as `now − head_stamp`, CNT_W bits, modulo. Wrap-around is correct because MAX_DLY < 2^CNT_W−1.
- Per edge, with `en_i`=1 and evaluation done before the push:
  - **Pass (head):** the FIFO is non-empty, `cons_i`=1, and MIN_DLY ≤ age ≤ MAX_DLY. Pop the head and pass.
  - **Fail:** the FIFO is non-empty, age == MAX_DLY, and no pass occurred. Pop the head and fail.
  - **Pass (immediate):** MIN_DLY=0, the FIFO is empty, and `ante_i`=`cons_i`=1. Pass at once; nothing is pushed.
  - A consequent retires at most one attempt per cycle, always the oldest. A consequent arriving before the head's MIN_DLY is ignored.
  - **Push:** `ante_i`=1 and the immediate-pass rule did not apply. Push stamp `now`.
  - **Overflow:** if the FIFO is full after any pop, drop the attempt and pulse `overflow_o`.
- Simultaneous pop and push in one cycle is legal. `pending_o` is unchanged in that case.
- `en_i`=0:
  - Clear the FIFO; `pending_o`→0 on the next edge.
  - No pass, fail or overflow is produced.
  - `now` keeps counting.
  - `fail_cnt_o` and the sticky state are held.
- `fail_cnt_o` increments on each fail and saturates at 0xFFFF.

## Timing
- All outputs are registered and reflect the evaluating edge. For an antecedent sampled at edge T:
  - The earliest pass pulse is visible after edge T+MIN_DLY.
  - A fail pulse is visible after edge T+MAX_DLY.
- Reset values: every output is 0, `now`=0, the FIFO is empty.
- Reset mid-operation drops all pending attempts silently; no fail is reported.
- Pulses never last longer than one cycle. `pass_o` and `fail_o` are mutually exclusive.

## Configuration
- `IMPL_CHK_STICKY_EN` defined:
  - `err_sticky_o` sets on the first fail or overflow and clears only on reset.
  - `first_fail_ts_o` captures `now` at the first fail and then holds.
- Not defined: both outputs are tied to 0 and no sticky registers are built. All other behaviour is identical.

## Test plan
1. MIN=1, MAX=4. Drive `ante_i` at cycle 10 and `cons_i` at cycle 13 → `pass_o` pulses once; `pending_o` goes 1 then 0.
2. MIN=1, MAX=4. Drive `ante_i` at cycle 10 and no consequent → `fail_o` pulses after edge 14; `fail_cnt_o`=1.
3. MIN=0. Drive `ante_i` and `cons_i` together at cycle 5 with the FIFO empty → immediate `pass_o`; `pending_o` stays 0.
4. DEPTH=4, MAX=8. Drive antecedents on 5 consecutive cycles with no consequent → the 5th raises `overflow_o`. Exactly 4 fails follow on consecutive cycles.
5. CNT_W=4, MAX=4, attempt started at `now`=14 → a consequent at `now`=1 (age 3) passes across the wrap.
6. Two attempts pending, then `en_i`=0 for one cycle → `pending_o`=0 with no fail. With `IMPL_CHK_STICKY_EN`, a prior fail at `now`=0x23 leaves `first_fail_ts_o`=0x23 through later fails.

Source files
------------

// File: rtl/impl_window_checker.sv
// -----------------------------------------------------------------------------
// impl_window_checker
//
// Runtime monitor for the implication property
//     ante |-> ##[MIN_DLY:MAX_DLY] cons
//
// Every antecedent opens one attempt. Its start stamp is pushed into a
// DEPTH-entry FIFO, so the head is always the oldest open attempt. Each cycle
// the head is aged against a free-running timestamp counter:
//   - a consequent inside the head's window retires the head as a pass,
//   - a head that reaches MAX_DLY without a consequent retires as a fail.
// At most one attempt retires per cycle, always the oldest. With MIN_DLY = 0
// an antecedent and consequent that arrive together while nothing is pending
// pass at once and are never stored.
//
// Parameters
//   MIN_DLY  earliest consequent cycle after the antecedent (0 = overlapped)
//   MAX_DLY  latest consequent cycle; MIN_DLY <= MAX_DLY < 2**CNT_W - 1
//   DEPTH    maximum outstanding attempts, power of two >= 2
//   CNT_W    width of the free-running timestamp counter
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   en_i             checker enable; low flushes all attempts
//   ante_i           antecedent, sampled every cycle
//   cons_i           consequent, sampled every cycle
//   pass_o           one-cycle pulse: an attempt passed
//   fail_o           one-cycle pulse: an attempt's window expired
//   overflow_o       one-cycle pulse: antecedent dropped, tracker full
//   pending_o        number of outstanding attempts
//   fail_cnt_o       saturating fail count
//   err_sticky_o     sticky error flag (optional feature)
//   first_fail_ts_o  timestamp of the first fail (optional feature)
//
// Optional feature macro: IMPL_CHK_STICKY_EN
//   Defined:   err_sticky_o sets on the first fail or overflow and clears only
//              on reset; first_fail_ts_o captures the timestamp of the first
//              fail and holds it.
//   Undefined: both outputs are tied to zero and no sticky state is built.
// -----------------------------------------------------------------------------
module impl_window_checker #(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       ante_i,
    input  logic                       cons_i,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic [15:0]                fail_cnt_o,
    output logic                       err_sticky_o,
    output logic [CNT_W-1:0]           first_fail_ts_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PEND_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(MIN_DLY);
    localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_DLY);
    localparam logic [PEND_W-1:0] DEPTH_C = PEND_W'(DEPTH);
    localparam logic              IMM_EN  = (MIN_DLY == 0);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]  now_q;
    logic [CNT_W-1:0]  now_d;
    logic [CNT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PEND_W-1:0] count_q, count_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       fail_cnt_q, fail_cnt_d;

    // -------------------------------------------------------------------------
    // Head evaluation
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]  head_stamp;
    logic [CNT_W-1:0]  head_age;
    logic              nonempty;
    logic              age_ge_min;
    logic              age_le_max;
    logic              pass_head;
    logic              fail_hit;
    logic              imm_pass;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              overflow;
    logic [PEND_W-1:0] count_after_pop;
    logic              full_after_pop;

    assign head_stamp = mem_q[rd_ptr_q];
    // Modulo subtraction: the head can never be older than MAX_DLY, which is
    // below the counter period, so a wrapped difference is still the true age.
    assign head_age   = now_q - head_stamp;
    assign nonempty   = (count_q != '0);
    assign age_le_max = (head_age <= MAX_C);

    // A zero lower bound makes the compare trivially true; build it away so
    // the unsigned ">= 0" never appears in the netlist.
    if (MIN_DLY == 0) begin : g_min_zero
        assign age_ge_min = 1'b1;
    end else begin : g_min_nonzero
        assign age_ge_min = (head_age >= MIN_C);
    end

    always_comb begin
        pass_head       = en_i && nonempty && cons_i && age_ge_min && age_le_max;
        // A consequent on the closing cycle wins over the expiry.
        fail_hit        = en_i && nonempty && (head_age == MAX_C) && !pass_head;
        // Only when nothing is pending; otherwise the consequent belongs to
        // the head and the new antecedent is queued behind it.
        imm_pass        = en_i && IMM_EN && !nonempty && ante_i && cons_i;
        pop             = pass_head || fail_hit;
        push_req        = en_i && ante_i && !imm_pass;
        count_after_pop = count_q - PEND_W'(pop);
        // Fullness is judged after this cycle's retirement so a pop and a
        // push can share a cycle at full occupancy.
        full_after_pop  = (count_after_pop == DEPTH_C);
        overflow        = push_req && full_after_pop;
        push            = push_req && !full_after_pop;
    end

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    always_comb begin
        now_d      = now_q + CNT_W'(1);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        ovf_d      = 1'b0;
        fail_cnt_d = fail_cnt_q;

        if (en_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_after_pop + PEND_W'(push);
            pass_d   = pass_head || imm_pass;
            fail_d   = fail_hit;
            ovf_d    = overflow;
            if (fail_hit && (fail_cnt_q != 16'hFFFF)) begin
                fail_cnt_d = fail_cnt_q + 16'd1;
            end
        end else begin
            // Disable flushes every attempt silently; the counter keeps
            // running and the fail count is held.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            ovf_q      <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            now_q      <= now_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ovf_q      <= ovf_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Stamp storage. Entries are only read while counted as pending, so the
    // reset value is irrelevant to behaviour; it keeps simulation X-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= now_q;
        end
    end

    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign overflow_o = ovf_q;
    assign pending_o  = count_q;
    assign fail_cnt_o = fail_cnt_q;

    // -------------------------------------------------------------------------
    // Sticky error capture
    // -------------------------------------------------------------------------
`ifdef IMPL_CHK_STICKY_EN
    logic             err_sticky_q, err_sticky_d;
    logic             fail_seen_q, fail_seen_d;
    logic [CNT_W-1:0] first_ts_q, first_ts_d;

    always_comb begin
        err_sticky_d = err_sticky_q;
        fail_seen_d  = fail_seen_q;
        first_ts_d   = first_ts_q;
        // fail_hit and overflow are already gated by en_i.
        if (fail_hit || overflow) begin
            err_sticky_d = 1'b1;
        end
        // A separate "seen" bit is needed: an overflow may set the sticky
        // flag before any fail has happened.
        if (fail_hit && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            first_ts_d  = now_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            fail_seen_q  <= 1'b0;
            first_ts_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            fail_seen_q  <= fail_seen_d;
            first_ts_q   <= first_ts_d;
        end
    end

    assign err_sticky_o    = err_sticky_q;
    assign first_fail_ts_o = first_ts_q;
`else
    assign err_sticky_o    = 1'b0;
    assign first_fail_ts_o = '0;
`endif

endmodule

// File: tb/tb_impl_window_checker.sv
// -----------------------------------------------------------------------------
// tb_impl_window_checker
//
// Two checkers share one stimulus stream:
//   dut_a : MIN=1, MAX=4, DEPTH=4, CNT_W=8   (non-overlapped window)
//   dut_b : MIN=0, MAX=8, DEPTH=4, CNT_W=4   (overlapped, short counter
//                                             that wraps every 16 cycles)
// A queue-of-start-cycles model per checker, using absolute cycle numbers,
// predicts every output after every edge.
// -----------------------------------------------------------------------------
module tb_impl_window_checker;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n;
    logic en_i, ante_i, cons_i;

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUTs
    logic       pass_a, fail_a, ovf_a, sticky_a;
    logic [2:0] pend_a;
    logic [15:0] fcnt_a;
    logic [7:0] ffts_a;

    logic       pass_b, fail_b, ovf_b, sticky_b;
    logic [2:0] pend_b;
    logic [15:0] fcnt_b;
    logic [3:0] ffts_b;

    impl_window_checker #(.MIN_DLY(1), .MAX_DLY(4), .DEPTH(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .ante_i(ante_i), .cons_i(cons_i),
        .pass_o(pass_a), .fail_o(fail_a), .overflow_o(ovf_a), .pending_o(pend_a),
        .fail_cnt_o(fcnt_a), .err_sticky_o(sticky_a), .first_fail_ts_o(ffts_a)
    );

    impl_window_checker #(.MIN_DLY(0), .MAX_DLY(8), .DEPTH(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .ante_i(ante_i), .cons_i(cons_i),
        .pass_o(pass_b), .fail_o(fail_b), .overflow_o(ovf_b), .pending_o(pend_b),
        .fail_cnt_o(fcnt_b), .err_sticky_o(sticky_b), .first_fail_ts_o(ffts_b)
    );

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Attempts are kept as absolute start cycles; age is a plain difference.
    int tnow;
    int q_a[$];
    int q_b[$];
    int e_pass[2], e_fail[2], e_ovf[2], e_pend[2], e_fcnt[2];
    int e_sticky[2], e_ffts[2], e_seen[2];

    task automatic model_reset();
        tnow = 0;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 2; i++) begin
            e_pass[i] = 0; e_fail[i] = 0; e_ovf[i] = 0; e_pend[i] = 0;
            e_fcnt[i] = 0; e_sticky[i] = 0; e_ffts[i] = 0; e_seen[i] = 0;
        end
    endtask

    task automatic model_inst(input int idx, input int mn, input int mx, input int dp,
                              input int w, input bit en, input bit ante, input bit cons);
        int q[$];
        int age;
        bit imm;
        if (idx == 0) q = q_a; else q = q_b;
        e_pass[idx] = 0;
        e_fail[idx] = 0;
        e_ovf[idx]  = 0;
        imm = 0;
        if (!en) begin
            q.delete();
        end else begin
            if (q.size() > 0) begin
                age = tnow - q[0];
                if (cons && age >= mn && age <= mx) begin
                    e_pass[idx] = 1;
                    void'(q.pop_front());
                end else if (age == mx) begin
                    e_fail[idx] = 1;
                    void'(q.pop_front());
                end
            end else if (mn == 0 && ante && cons) begin
                imm = 1;
                e_pass[idx] = 1;
            end
            if (ante && !imm) begin
                if (q.size() == dp) e_ovf[idx] = 1;
                else q.push_back(tnow);
            end
            if (e_fail[idx] == 1) begin
                if (e_fcnt[idx] < 65535) e_fcnt[idx]++;
                if (e_seen[idx] == 0) begin
                    e_seen[idx] = 1;
                    e_ffts[idx] = tnow % (1 << w);
                end
            end
            if (e_fail[idx] == 1 || e_ovf[idx] == 1) e_sticky[idx] = 1;
        end
        e_pend[idx] = q.size();
        if (idx == 0) q_a = q; else q_b = q;
    endtask

    function automatic int sticky_exp(input int idx);
`ifdef IMPL_CHK_STICKY_EN
        return e_sticky[idx];
`else
        return (idx < 0) ? 1 : 0;
`endif
    endfunction

    function automatic int ffts_exp(input int idx);
`ifdef IMPL_CHK_STICKY_EN
        return e_ffts[idx];
`else
        return (idx < 0) ? 1 : 0;
`endif
    endfunction

    task automatic check_all();
        chk("a_pass",    32'(pass_a),   e_pass[0]);
        chk("a_fail",    32'(fail_a),   e_fail[0]);
        chk("a_ovf",     32'(ovf_a),    e_ovf[0]);
        chk("a_pending", 32'(pend_a),   e_pend[0]);
        chk("a_failcnt", 32'(fcnt_a),   e_fcnt[0]);
        chk("a_sticky",  32'(sticky_a), sticky_exp(0));
        chk("a_ffts",    32'(ffts_a),   ffts_exp(0));
        chk("b_pass",    32'(pass_b),   e_pass[1]);
        chk("b_fail",    32'(fail_b),   e_fail[1]);
        chk("b_ovf",     32'(ovf_b),    e_ovf[1]);
        chk("b_pending", 32'(pend_b),   e_pend[1]);
        chk("b_failcnt", 32'(fcnt_b),   e_fcnt[1]);
        chk("b_sticky",  32'(sticky_b), sticky_exp(1));
        chk("b_ffts",    32'(ffts_b),   ffts_exp(1));
    endtask

    // ---------------------------------------------------------------- driver tasks
    // Called just after a falling edge; returns just after the next one.
    task automatic step(input bit en, input bit ante, input bit cons);
        en_i   = en;
        ante_i = ante;
        cons_i = cons;
        model_inst(0, 1, 4, 4, 8, en, ante, cons);
        model_inst(1, 0, 8, 4, 4, en, ante, cons);
        tnow++;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_until_mod(input int m, input int v);
        for (int i = 0; i < 64 && (tnow % m) != v; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en_i   = 1'b0;
        ante_i = 1'b0;
        cons_i = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- directed + random sequence
    initial begin
        rst_n  = 1'b0;
        en_i   = 1'b0;
        ante_i = 1'b0;
        cons_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Window pass: antecedent at cycle 10, consequent at cycle 13.
        idle_until_mod(1 << 30, 10);
        step(1'b1, 1'b1, 1'b0);
        chk("p1_pending_one", 32'(pend_a), 1);
        idle(2);
        step(1'b1, 1'b0, 1'b1);
        chk("p1_pass", 32'(pass_a), 1);
        chk("p1_pending_zero", 32'(pend_a), 0);

        // Window expiry: fail four edges after the antecedent.
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        chk("p2_fail", 32'(fail_a), 1);
        chk("p2_failcnt", 32'(fcnt_a), 1);

        // Overlapped immediate pass on the empty MIN=0 checker.
        idle(6);
        step(1'b1, 1'b1, 1'b1);
        chk("p3_imm_pass", 32'(pass_b), 1);
        chk("p3_pending", 32'(pend_b), 0);
        idle(5);

        // Five back-to-back antecedents into a four-deep tracker.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("p4_overflow", 32'(ovf_b), 1);
        idle(10);

        // Pass across the 4-bit counter wrap: start at 14, consequent at 1.
        idle_until_mod(16, 14);
        step(1'b1, 1'b1, 1'b0);
        idle_until_mod(16, 1);
        step(1'b1, 1'b0, 1'b1);
        chk("p5_wrap_pass", 32'(pass_b), 1);

        // Disable flush with two attempts pending.
        idle(10);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("p6_flush_a", 32'(pend_a), 0);
        chk("p6_flush_b", 32'(pend_b), 0);
        idle(10);

        // Reset in the middle of pending attempts drops them silently.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        idle(12);

        // Randomised traffic.
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 19) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
